graph_buffer_writer: RTL and testbench

//  - Producer side of the bar-graph sample store. Accepts a stream of 8-bit samples and writes them in order into a ping-pong pair of DEPTH-entry banks.
//  - Serves per-pixel reads for the VGA graph drawer, which uses rd_addr = pixel_x.
//  - Swaps banks only at the start of vertical blank, so the drawer never shows a half-written graph.

---
 rtl/graph_pkg.sv | 14 +
 rtl/gbuf_dpram.sv | 32 +++
 rtl/graph_buffer_writer.sv | 118 +++++++++++
 tb/tb_graph_buffer_writer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// Shared constants and FSM state type for the bar-graph sample store.
package graph_pkg;

  localparam int GRAPH_DEPTH = 640;
  localparam int GRAPH_DW    = 8;
  localparam int GRAPH_AW    = 10;
  localparam int GRAPH_MAX_H = 239;

  typedef enum logic {
    FILL,
    WAIT_SWAP
  } gbw_state_e;

endpackage

// File: rtl/gbuf_dpram.sv
// Simple dual-port sample RAM: two DEPTH-entry banks, one write port and
// one registered read port. No reset so it maps onto block RAM.
module gbuf_dpram
  import graph_pkg::*;
#(
  parameter int DEPTH = GRAPH_DEPTH,
  parameter int DW    = GRAPH_DW,
  parameter int AW    = GRAPH_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2][DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[wbank_i][waddr_i] <= wdata_i;
    end
    rdata_q <= mem[rbank_i][raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/graph_buffer_writer.sv
// Ping-pong bar-graph sample store: fills the back bank from a stream and swaps
// banks on a vblank rise once full. Build option: GRAPH_CLAMP_EN clamps samples to MAX_H.
module graph_buffer_writer
  import graph_pkg::*;
#(
  parameter int DEPTH = GRAPH_DEPTH,
  parameter int DW    = GRAPH_DW,
  parameter int AW    = GRAPH_AW,
  parameter int MAX_H = GRAPH_MAX_H
) (
  input  logic          clk,
  input  logic          _rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          vblank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_rdy,
  output logic          swap_pulse,
  output logic          front_sel
);

`ifdef GRAPH_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  gbw_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          s_ready_q;
  logic          frame_rdy_q, frame_rdy_d;
  logic          front_sel_q, front_sel_d;
  logic          vblank_q;
  logic          rd_ok_q;
  logic          xfer, rise, swap;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] ram_rdata;

  assign xfer    = s_valid & s_ready_q;
  assign rise    = vblank & ~vblank_q;
  assign wr_data = (CLAMP && (s_data > DW'(MAX_H))) ? DW'(MAX_H) : s_data;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frame_rdy_d = frame_rdy_q;
    front_sel_d = front_sel_q;
    swap        = 1'b0;
    case (state_q)
      FILL: begin
        // A rise here is ignored, including one coinciding with the last write.
        if (xfer) begin
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            wr_ptr_d    = '0;
            frame_rdy_d = 1'b1;
            state_d     = WAIT_SWAP;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (rise) begin
          swap        = 1'b1;
          front_sel_d = ~front_sel_q;
          frame_rdy_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // s_ready is registered from the next state, so it never depends on s_valid.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      frame_rdy_q <= 1'b0;
      front_sel_q <= 1'b0;
      vblank_q    <= 1'b1;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      s_ready_q   <= (state_d == FILL);
      frame_rdy_q <= frame_rdy_d;
      front_sel_q <= front_sel_d;
      vblank_q    <= vblank;
      rd_ok_q     <= ({1'b0, rd_addr} < (AW + 1)'(DEPTH));
    end
  end

  gbuf_dpram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (xfer),
    .wbank_i (~front_sel_q),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .rbank_i (front_sel_q),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign s_ready    = s_ready_q;
  assign frame_rdy  = frame_rdy_q;
  assign front_sel  = front_sel_q;
  assign swap_pulse = swap;
  assign rd_data    = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_graph_buffer_writer.sv
// Randomized self-checking bench for graph_buffer_writer against a frame-level
// model of the two sample banks.
module tb_graph_buffer_writer;

  localparam int DEPTH = 640;

  logic       clk = 1'b0;
  logic       _rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       vblank;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_rdy;
  logic       swap_pulse;
  logic       front_sel;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: bank contents, how many samples the back bank holds,
  // whether the frame is complete, and which bank is displayed.
  int m_bank  [2][DEPTH];
  bit m_known [2][DEPTH];
  int m_count;
  bit m_full;
  int m_front;
  bit m_ready;
  bit m_prev_vb;
  bit m_rd_chk;
  int m_rd_val;

  graph_buffer_writer dut (
    .clk        (clk),
    ._rst       (_rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .vblank     (vblank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_rdy  (frame_rdy),
    .swap_pulse (swap_pulse),
    .front_sel  (front_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int stored(input int d);
`ifdef GRAPH_CLAMP_EN
    return (d > 239) ? 239 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [9:0] rnd_addr();
    return 10'($urandom_range(0, 767));
  endfunction

  task automatic model_reset();
    m_count   = 0;
    m_full    = 1'b0;
    m_front   = 0;
    m_ready   = 1'b0;
    m_prev_vb = 1'b1;
    m_rd_chk  = 1'b1;
    m_rd_val  = 0;
  endtask

  // Called just after a falling edge: drive, check current outputs, advance model.
  task automatic step(input logic v, input logic [7:0] d, input logic vb, input logic [9:0] a);
    bit rise, do_swap;
    int ia;
    s_valid = v;
    s_data  = d;
    vblank  = vb;
    rd_addr = a;
    #1;
    rise    = vb && !m_prev_vb;
    do_swap = m_full && rise;
    check("s_ready", int'(s_ready), int'(m_ready));
    check("frame_rdy", int'(frame_rdy), int'(m_full));
    check("front_sel", int'(front_sel), m_front);
    check("swap_pulse", int'(swap_pulse), int'(do_swap));
    if (m_rd_chk) check("rd_data", int'(rd_data), m_rd_val);

    ia = int'(a);
    if (ia >= DEPTH) begin
      m_rd_chk = 1'b1;
      m_rd_val = 0;
    end else begin
      m_rd_chk = m_known[m_front][ia];
      m_rd_val = m_bank[m_front][ia];
    end
    if (v && m_ready) begin
      m_bank[1 - m_front][m_count]  = stored(int'(d));
      m_known[1 - m_front][m_count] = 1'b1;
      m_count++;
      if (m_count == DEPTH) begin
        m_count = 0;
        m_full  = 1'b1;
      end
    end
    if (do_swap) begin
      m_front = 1 - m_front;
      m_full  = 1'b0;
    end
    m_ready   = !m_full;
    m_prev_vb = vb;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    _rst    = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    vblank  = 1'b1;
    rd_addr = 10'd3;
    repeat (cycles) @(negedge clk);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_frame_rdy", int'(frame_rdy), 0);
    check("rst_front_sel", int'(front_sel), 0);
    check("rst_swap_pulse", int'(swap_pulse), 0);
    check("rst_rd_data", int'(rd_data), 0);
    model_reset();
    _rst = 1'b1;
  endtask

  // mode 0: data = address, 1: random, 2: address except 250 at address 7
  task automatic fill(input int n, input int mode, input bit gaps);
    int done = 0;
    int guard = 0;
    logic v;
    logic [7:0] d;
    while (done < n && guard < 4 * n + 100) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (mode)
        0:       d = 8'(m_count);
        1:       d = 8'($urandom);
        default: d = (m_count == 7) ? 8'd250 : 8'(m_count);
      endcase
      if (v && m_ready) done++;
      step(v, d, 1'b0, rnd_addr());
      guard++;
    end
    if (done < n) check("fill_timeout", done, n);
  endtask

  task automatic vpulse();
    repeat (2) step(1'b0, 8'(0), 1'b1, rnd_addr());
    repeat (2) step(1'b0, 8'(0), 1'b0, rnd_addr());
  endtask

  initial begin
    int fs;
    int clamp_exp;
    _rst = 1'b0;
    @(negedge clk);

    // Reset with s_valid held high, then release.
    do_reset(3);
    step(1'b1, 8'd9, 1'b1, 10'd0);
    step(1'b0, 8'd0, 1'b1, 10'd0);
    check("ready_after_rel", int'(s_ready), 1);

    // Full frame of address-valued samples, then swap and read back.
    repeat (3) step(1'b0, 8'd0, 1'b0, rnd_addr());
    fill(DEPTH, 0, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0, rnd_addr());
    check("fill_frame_rdy", int'(frame_rdy), 1);
    check("fill_s_ready", int'(s_ready), 0);
    vpulse();
    check("swap_front_sel", int'(front_sel), 1);
    step(1'b0, 8'd0, 1'b0, 10'd5);
    check("rd_addr5", int'(rd_data), 5);

    // Back-pressure: valid held while waiting for a swap.
    fill(DEPTH, 1, 1'b1);
    repeat (100) step(1'b1, 8'($urandom), 1'b0, rnd_addr());
    vpulse();
    check("bp_front_sel", int'(front_sel), 0);
    fill(DEPTH, 1, 1'b1);
    vpulse();

    // Early vblank with a half-filled back bank.
    fs = int'(front_sel);
    fill(300, 0, 1'b0);
    vpulse();
    check("early_no_swap", int'(front_sel), fs);
    fill(DEPTH - 300, 1, 1'b0);
    vpulse();
    check("early_then_swap", int'(front_sel), 1 - fs);

    // Last transfer coinciding with a vblank rise.
    fs = int'(front_sel);
    fill(DEPTH - 1, 1, 1'b0);
    step(1'b1, 8'($urandom), 1'b1, rnd_addr());
    repeat (3) step(1'b0, 8'd0, 1'b1, rnd_addr());
    check("coinc_no_swap", int'(front_sel), fs);
    check("coinc_frame_rdy", int'(frame_rdy), 1);
    step(1'b0, 8'd0, 1'b0, rnd_addr());
    vpulse();
    check("coinc_next_swap", int'(front_sel), 1 - fs);

    // Over-height sample at address 7 and an out-of-range read.
    fill(DEPTH, 2, 1'b1);
    vpulse();
    step(1'b0, 8'd0, 1'b0, 10'd7);
`ifdef GRAPH_CLAMP_EN
    clamp_exp = 239;
`else
    clamp_exp = 250;
`endif
    check("clamp_addr7", int'(rd_data), clamp_exp);
    step(1'b0, 8'd0, 1'b0, 10'd700);
    check("rd_addr700", int'(rd_data), 0);

    // Reset part-way through a fill discards the partial frame.
    fill(100, 1, 1'b0);
    do_reset(2);
    fill(DEPTH, 1, 1'b1);
    vpulse();
    check("post_rst_swap", int'(front_sel), 1);

    // Free-running random traffic with periodic vblank.
    for (int c = 0; c < 3000; c++) begin
      step(1'b1 & ($urandom_range(0, 3) != 0), 8'($urandom),
           1'b1 & ((c % 850) < 30), rnd_addr());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
